turbo_intlv: RTL

- Bit-serial block interleaver for the turbo encoder's second constituent branch.
- Consumes the same serial systematic bit stream that drives the first constituent encoder (the parallel-to-serial output with its enable).
- Delivers the permuted stream, with frame markers, to the second constituent encoder.
- Row-write / column-read permutation over a ROWS x COLS frame; two-bank ping-pong buffering so input and output run concurrently.

---
 rtl/turbo_intlv.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/turbo_intlv.sv
// turbo_intlv: bit-serial row-write / column-read block interleaver with two-bank
// ping-pong storage, feeding the second constituent encoder of a turbo encoder.
//
// Parameters:
//   ROWS, COLS : interleaver geometry (each >= 2); frame length N = ROWS*COLS.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   din        : serial input bit
//   din_valid  : din presented this cycle
//   din_ready  : block accepts a bit this cycle (depends on registered state only)
//   dout       : interleaved output bit (registered, 0 when not valid)
//   dout_valid : dout valid
//   dout_sof   : first bit of an output frame
//   dout_eof   : last bit of an output frame
//   ovf_err    : sticky "bit offered while not ready" flag; present only when the
//                TURBO_INTLV_OVF_EN macro is defined
module turbo_intlv #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  output logic dout,
  output logic dout_valid,
  output logic dout_sof,
`ifdef TURBO_INTLV_OVF_EN
  output logic dout_eof,
  output logic ovf_err
`else
  output logic dout_eof
`endif
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam logic [RW-1:0] RowMax = RW'(ROWS - 1);
  localparam logic [RW-1:0] RowPre = RW'(ROWS - 2);
  localparam logic [CW-1:0] ColMax = CW'(COLS - 1);
  localparam logic [AW-1:0] WrMax  = AW'(N - 1);

  typedef enum logic {StIdle, StRead} state_e;

  logic [N-1:0]  mem_q [2];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  // Bank actually being read; rd_bank_q moves on one address early (see release).
  logic          bank_sel_q, bank_sel_d;
  state_e        state_q, state_d;
  logic [RW-1:0] rr_q, rr_d;
  logic [CW-1:0] cc_q, cc_d;
  logic          dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;

  logic          wr_en, wr_last, rd_last, rd_pre;
  logic [AW-1:0] rd_addr;

  assign din_ready = ~full_q[wr_bank_q];
  assign wr_en     = din_valid & din_ready;
  assign wr_last   = (wr_cnt_q == WrMax);
  assign rd_last   = (rr_q == RowMax) && (cc_q == ColMax);
  // Counters sit one address short of the end: the next edge issues the last address.
  assign rd_pre    = (rr_q == RowPre) && (cc_q == ColMax);
  assign rd_addr   = AW'(rr_q) * AW'(COLS) + AW'(cc_q);

  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    full_d       = full_q;
    rd_bank_d    = rd_bank_q;
    bank_sel_d   = bank_sel_q;
    state_d      = state_q;
    rr_d         = rr_q;
    cc_d         = cc_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;

    if (wr_en) begin
      if (wr_last) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d    = StRead;
          rr_d       = '0;
          cc_d       = '0;
          bank_sel_d = rd_bank_q;
        end
      end
      StRead: begin
        dout_valid_d = 1'b1;
        dout_d       = mem_q[bank_sel_q][rd_addr];
        sof_d        = (rr_q == '0) && (cc_q == '0);
        eof_d        = rd_last;
        if (rd_last) begin
          rr_d = '0;
          cc_d = '0;
          // rd_bank_q already points at the other bank here.
          if (full_q[rd_bank_q]) begin
            bank_sel_d = rd_bank_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (rr_q == RowMax) begin
            rr_d = '0;
            cc_d = cc_q + 1'b1;
          end else begin
            rr_d = rr_q + 1'b1;
          end
          // Release on the edge that issues the last address so the writer can
          // refill this bank without a stall; the final read still uses bank_sel_q.
          if (rd_pre) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      bank_sel_q   <= 1'b0;
      state_q      <= StIdle;
      rr_q         <= '0;
      cc_q         <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_bank_q    <= rd_bank_d;
      bank_sel_q   <= bank_sel_d;
      state_q      <= state_d;
      rr_q         <= rr_d;
      cc_q         <= cc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
    end
  end

  // Storage needs no reset: a bank is only read after it has been completely written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_cnt_q] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_sof   = sof_q;
  assign dout_eof   = eof_q;

`ifdef TURBO_INTLV_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (din_valid && !din_ready) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`endif

endmodule
